// File: rtl/aiv_framebuffer_writer_pkg.sv
// Shared definitions for the AIV framebuffer writer: word layout, FSM encodings, SRAM widths.
package aiv_framebuffer_writer_pkg;
  localparam int PIXELS_PER_WORD = 5;
  localparam int PIX_BITS        = 3;
  localparam int ADDR_W          = 18;
  localparam int DATA_W          = 16;

  // Bit positions of each colour inside a 3-bit pixel slot
  localparam int R_BIT = 2;
  localparam int G_BIT = 1;
  localparam int B_BIT = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fbWord_t;
endpackage

// File: rtl/aiv_framebuffer_writer_if.sv
// Pixel-stream inputs and SRAM write-port outputs of the framebuffer writer.
interface aiv_framebuffer_writer_if;
  logic        pixel_en;
  logic        red_in;
  logic        green_in;
  logic        blue_in;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        display_enable;
  logic        sram_hold;
  logic [17:0] SRAM0_A;
  logic [15:0] SRAM0_D_out;
  logic        SRAM0_D_oe;
  logic        SRAM0_nCS;
  logic        SRAM0_nWE;
  logic        SRAM0_nOE;
  logic        overflow;

  modport master (
    output pixel_en, red_in, green_in, blue_in, pixel_x, pixel_y, display_enable, sram_hold,
    input  SRAM0_A, SRAM0_D_out, SRAM0_D_oe, SRAM0_nCS, SRAM0_nWE, SRAM0_nOE, overflow
  );

  modport slave (
    input  pixel_en, red_in, green_in, blue_in, pixel_x, pixel_y, display_enable, sram_hold,
    output SRAM0_A, SRAM0_D_out, SRAM0_D_oe, SRAM0_nCS, SRAM0_nWE, SRAM0_nOE, overflow
  );
endinterface

// File: rtl/aiv_word_fifo.sv
// Small synchronous first-word-fall-through FIFO of {addr,data} framebuffer words.
module aiv_word_fifo
  import aiv_framebuffer_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  fbWord_t din,
  input  logic    pop,
  output fbWord_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  fbWord_t        mem [DEPTH];
  logic [AW:0]    wrPtr, rdPtr;
  logic           wrOk, rdOk;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign rdOk  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wrOk  = push && (!full || rdOk);
  assign dout  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wrOk) mem[wrPtr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + 1'b1;
      if (rdOk) rdPtr <= rdPtr + 1'b1;
    end
  end
endmodule

// File: rtl/aiv_framebuffer_writer.sv
// Packs active-area RGB111 pixels five per word and writes them into the K6R4016 SRAM.
module aiv_framebuffer_writer
  import aiv_framebuffer_writer_pkg::*;
#(
  parameter int ACTIVE_WIDTH   = 720,
  parameter int ACTIVE_LINES   = 576,
  parameter int WORDS_PER_LINE = (ACTIVE_WIDTH + PIXELS_PER_WORD - 1) / PIXELS_PER_WORD,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                  clk,
  input logic                  reset,
  aiv_framebuffer_writer_if.slave bus
);
  localparam int                IDX_W   = $clog2(WORDS_PER_LINE + 1);
  localparam logic [IDX_W-1:0]  WPL_V   = IDX_W'(WORDS_PER_LINE);
  localparam logic [9:0]        LINES_V = 10'(ACTIVE_LINES);
  localparam logic [2:0]        LAST_PX = 3'(PIXELS_PER_WORD - 1);

  logic              deQ, deRise, deFall, accept;
  logic [2:0]        pixCnt, curCnt;
  logic [IDX_W-1:0]  wordIdx, curIdx;
  logic [DATA_W-1:0] packData, curData, newData;
  logic [PIX_BITS-1:0] pix;
  logic [ADDR_W-1:0] lineBase, lineBaseNext;
  logic              wordReady, overflowQ;
  fbWord_t           pend, fifoOut;
  logic              fifoFull, fifoEmpty, fsmPop;

  logic [1:0]        state;
  logic [ADDR_W-1:0] aReg;
  logic [DATA_W-1:0] dReg;
  logic              oeReg, csReg, weReg;

  logic unusedPixelX;
  assign unusedPixelX = ^bus.pixel_x;

  // A rising display_enable restarts the line even if the previous one was cut short
  always_comb begin
    deRise       = bus.display_enable && !deQ;
    deFall       = !bus.display_enable && deQ;
    curCnt       = deRise ? 3'd0 : pixCnt;
    curIdx       = deRise ? '0 : wordIdx;
    curData      = deRise ? '0 : packData;
    pix          = '0;
    pix[R_BIT]   = bus.red_in;
    pix[G_BIT]   = bus.green_in;
    pix[B_BIT]   = bus.blue_in;
    newData      = curData | (DATA_W'(pix) << (PIX_BITS * curCnt));
    lineBaseNext = ADDR_W'(bus.pixel_y) * ADDR_W'(WORDS_PER_LINE);
    accept       = bus.pixel_en && bus.display_enable && (bus.pixel_y < LINES_V) && (curIdx < WPL_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deQ       <= 1'b0;
      pixCnt    <= '0;
      wordIdx   <= '0;
      packData  <= '0;
      lineBase  <= '0;
      wordReady <= 1'b0;
      pend      <= '0;
    end else begin
      deQ       <= bus.display_enable;
      wordReady <= 1'b0;
      if (deRise) begin
        pixCnt   <= '0;
        wordIdx  <= '0;
        packData <= '0;
      end
      if (accept) begin
        if (curCnt == 3'd0 && curIdx == '0) lineBase <= lineBaseNext;
        if (curCnt == LAST_PX) begin
          wordReady <= 1'b1;
          pend      <= '{addr: lineBase + ADDR_W'(curIdx), data: newData};
          pixCnt    <= '0;
          packData  <= '0;
          wordIdx   <= curIdx + 1'b1;
        end else begin
          pixCnt    <= curCnt + 1'b1;
          packData  <= newData;
        end
      end else if (deFall) begin
        // Partial word at end of line: unused upper slots are already zero
        if (pixCnt != 3'd0) begin
          wordReady <= 1'b1;
          pend      <= '{addr: lineBase + ADDR_W'(wordIdx), data: packData};
        end
        pixCnt   <= '0;
        wordIdx  <= '0;
        packData <= '0;
      end
    end
  end

  aiv_word_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (wordReady),
    .din   (pend),
    .pop   (fsmPop),
    .dout  (fifoOut),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign fsmPop = (state == ST_IDLE) && !fifoEmpty && !bus.sram_hold;

  always_ff @(posedge clk) begin
    if (reset) overflowQ <= 1'b0;
    else if (wordReady && fifoFull && !fsmPop) overflowQ <= 1'b1;
  end

  // Chip select spans SETUP..RECOVER with the single write strobe in the middle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      aReg  <= '0;
      dReg  <= '0;
      oeReg <= 1'b0;
      csReg <= 1'b1;
      weReg <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (fsmPop) begin
          aReg  <= fifoOut.addr;
          dReg  <= fifoOut.data;
          oeReg <= 1'b1;
          csReg <= 1'b0;
          state <= ST_SETUP;
        end
        ST_SETUP: begin
          weReg <= 1'b0;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          weReg <= 1'b1;
          state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          csReg <= 1'b1;
          oeReg <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SRAM0_A     = aReg;
  assign bus.SRAM0_D_out = dReg;
  assign bus.SRAM0_D_oe  = oeReg;
  assign bus.SRAM0_nCS   = csReg;
  assign bus.SRAM0_nWE   = weReg;
  assign bus.SRAM0_nOE   = 1'b1;
  assign bus.overflow    = overflowQ;
endmodule

// File: tb/tb_aiv_framebuffer_writer.sv
// Directed bench: two writer instances (720- and 722-pixel lines) fed from one pixel stream.
module tb_aiv_framebuffer_writer;
  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic pen, r, g, b, de, hold;
  logic [9:0] py;
  int errors = 0;
  int checks = 0;
  wr_t qA[$];
  wr_t qB[$];
  logic [2:0] pix [0:1023];

  always #5 clk = ~clk;

  aiv_framebuffer_writer_if busA();
  aiv_framebuffer_writer_if busB();

  assign busA.pixel_en = pen;  assign busB.pixel_en = pen;
  assign busA.red_in = r;      assign busB.red_in = r;
  assign busA.green_in = g;    assign busB.green_in = g;
  assign busA.blue_in = b;     assign busB.blue_in = b;
  assign busA.pixel_x = 10'd0; assign busB.pixel_x = 10'd0;
  assign busA.pixel_y = py;    assign busB.pixel_y = py;
  assign busA.display_enable = de; assign busB.display_enable = de;
  assign busA.sram_hold = hold;    assign busB.sram_hold = hold;

  aiv_framebuffer_writer #(.ACTIVE_WIDTH(720), .ACTIVE_LINES(576), .WORDS_PER_LINE(144), .FIFO_DEPTH(4))
    dutA (.clk(clk), .reset(reset), .bus(busA.slave));
  aiv_framebuffer_writer #(.ACTIVE_WIDTH(722), .ACTIVE_LINES(576), .WORDS_PER_LINE(145), .FIFO_DEPTH(4))
    dutB (.clk(clk), .reset(reset), .bus(busB.slave));

  // Record every write at its strobe cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (busA.SRAM0_nWE === 1'b0) qA.push_back({busA.SRAM0_A, busA.SRAM0_D_out});
      if (busB.SRAM0_nWE === 1'b0) qB.push_back({busB.SRAM0_A, busB.SRAM0_D_out});
    end
  end

  task automatic sendLine(input int y, input int n);
    @(negedge clk); py = 10'(y); de = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      {r, g, b} = pix[i]; pen = 1'b1;
      @(negedge clk); pen = 1'b0;
      repeat (5) @(negedge clk);
    end
    de = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitWrites(input bit sel, input int n, input int limit);
    int c = 0;
    while (((sel ? qB.size() : qA.size()) < n) && c < limit) begin
      @(negedge clk); c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pen = 0; r = 0; g = 0; b = 0; de = 0; hold = 0; py = '0;
    repeat (3) @(negedge clk);
    checks++; if (busA.SRAM0_nCS !== 1'b1) begin errors++; $display("FAIL reset_nCS got %b exp 1", busA.SRAM0_nCS); end
    checks++; if (busA.SRAM0_nWE !== 1'b1) begin errors++; $display("FAIL reset_nWE got %b exp 1", busA.SRAM0_nWE); end
    checks++; if (busA.SRAM0_nOE !== 1'b1) begin errors++; $display("FAIL reset_nOE got %b exp 1", busA.SRAM0_nOE); end
    checks++; if (busA.SRAM0_D_oe !== 1'b0) begin errors++; $display("FAIL reset_Doe got %b exp 0", busA.SRAM0_D_oe); end
    checks++; if (busA.SRAM0_A !== 18'd0) begin errors++; $display("FAIL reset_A got %h exp 0", busA.SRAM0_A); end
    checks++; if (busA.SRAM0_D_out !== 16'd0) begin errors++; $display("FAIL reset_D got %h exp 0", busA.SRAM0_D_out); end
    checks++; if (busA.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", busA.overflow); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency_timing();
    int lowCnt, weLow, wePos, doeBad;
    qA.delete(); qB.delete();
    @(negedge clk); py = 10'd3; de = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      {r, g, b} = 3'b111; pen = 1'b1;
      @(negedge clk); pen = 1'b0;
      if (i < 4) repeat (5) @(negedge clk);
    end
    checks++; if (busA.SRAM0_nCS !== 1'b1) begin errors++; $display("FAIL lat_N got nCS=%b exp 1", busA.SRAM0_nCS); end
    @(negedge clk);
    checks++; if (busA.SRAM0_nCS !== 1'b1) begin errors++; $display("FAIL lat_N1 got nCS=%b exp 1", busA.SRAM0_nCS); end
    @(negedge clk);
    checks++; if (busA.SRAM0_nCS !== 1'b0) begin errors++; $display("FAIL lat_N2 got nCS=%b exp 0", busA.SRAM0_nCS); end
    checks++; if (busA.SRAM0_A !== 18'd432) begin errors++; $display("FAIL white_A got %0d exp 432", busA.SRAM0_A); end
    checks++; if (busA.SRAM0_D_out !== 16'h7FFF) begin errors++; $display("FAIL white_D got %h exp 7fff", busA.SRAM0_D_out); end
    lowCnt = 1; weLow = (busA.SRAM0_nWE === 1'b0) ? 1 : 0; wePos = -1;
    doeBad = (busA.SRAM0_D_oe !== 1'b1) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busA.SRAM0_nCS !== 1'b0) break;
      lowCnt++;
      if (busA.SRAM0_D_oe !== 1'b1) doeBad++;
      if (busA.SRAM0_nWE === 1'b0) begin weLow++; wePos = lowCnt - 1; end
    end
    checks++; if (lowCnt !== 3) begin errors++; $display("FAIL nCS_low_len got %0d exp 3", lowCnt); end
    checks++; if (weLow !== 1) begin errors++; $display("FAIL nWE_low_len got %0d exp 1", weLow); end
    checks++; if (wePos !== 1) begin errors++; $display("FAIL nWE_pos got %0d exp 1", wePos); end
    checks++; if (doeBad !== 0) begin errors++; $display("FAIL Doe_during_cs got %0d bad cycles exp 0", doeBad); end
    checks++; if (busA.SRAM0_D_oe !== 1'b0) begin errors++; $display("FAIL Doe_after got %b exp 0", busA.SRAM0_D_oe); end
    de = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_full_line();
    int bad = 0;
    qA.delete(); qB.delete();
    for (int i = 0; i < 720; i++) pix[i] = (i % 2 == 0) ? 3'b100 : 3'b001;
    sendLine(0, 720);
    waitWrites(1'b0, 144, 100);
    repeat (20) @(negedge clk);
    checks++; if (qA.size() !== 144) begin errors++; $display("FAIL line_count got %0d exp 144", qA.size()); end
    for (int w = 0; w < 144 && w < qA.size(); w++) begin
      checks++;
      if (qA[w] !== {18'(w), ((w % 2 == 0) ? 16'h430C : 16'h1861)}) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL line_word%0d got a=%0d d=%h exp a=%0d d=%h", w, qA[w].a, qA[w].d, w,
                              (w % 2 == 0) ? 16'h430C : 16'h1861);
      end
    end
    checks++; if (busA.overflow !== 1'b0) begin errors++; $display("FAIL line_ovf got %b exp 0", busA.overflow); end
  endtask

  task automatic test_width_722();
    qA.delete(); qB.delete();
    for (int i = 0; i < 722; i++) pix[i] = (i >= 720) ? 3'b010 : 3'b000;
    sendLine(0, 722);
    waitWrites(1'b1, 145, 100);
    repeat (20) @(negedge clk);
    checks++; if (qB.size() !== 145) begin errors++; $display("FAIL w722_count got %0d exp 145", qB.size()); end
    if (qB.size() == 145) begin
      checks++; if (qB[144] !== {18'd144, 16'h0012}) begin errors++;
        $display("FAIL w722_last got a=%0d d=%h exp a=144 d=0012", qB[144].a, qB[144].d); end
      checks++; if (qB[143] !== {18'd143, 16'h0000}) begin errors++;
        $display("FAIL w722_prev got a=%0d d=%h exp a=143 d=0000", qB[143].a, qB[143].d); end
    end
    checks++; if (qA.size() !== 144) begin errors++; $display("FAIL w720_clip got %0d exp 144", qA.size()); end
  endtask

  task automatic test_hold_overflow();
    logic [15:0] expD [4];
    expD = '{16'h1249, 16'h2492, 16'h36DB, 16'h4924};
    qA.delete(); qB.delete();
    for (int i = 0; i < 25; i++) pix[i] = 3'(i / 5 + 1);
    hold = 1'b1;
    sendLine(1, 25);
    repeat (47) @(negedge clk);
    checks++; if (qA.size() !== 0) begin errors++; $display("FAIL hold_nowrite got %0d writes exp 0", qA.size()); end
    checks++; if (busA.overflow !== 1'b1) begin errors++; $display("FAIL hold_ovf got %b exp 1", busA.overflow); end
    hold = 1'b0;
    waitWrites(1'b0, 4, 100);
    repeat (30) @(negedge clk);
    checks++; if (qA.size() !== 4) begin errors++; $display("FAIL hold_count got %0d exp 4", qA.size()); end
    for (int w = 0; w < 4 && w < qA.size(); w++) begin
      checks++; if (qA[w] !== {18'(144 + w), expD[w]}) begin errors++;
        $display("FAIL hold_word%0d got a=%0d d=%h exp a=%0d d=%h", w, qA[w].a, qA[w].d, 144 + w, expD[w]); end
    end
    checks++; if (busA.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", busA.overflow); end
  endtask

  task automatic test_reset_strobe();
    int c = 0;
    for (int i = 0; i < 10; i++) pix[i] = 3'b110;
    hold = 1'b1;
    sendLine(5, 10);
    qA.delete(); qB.delete();
    hold = 1'b0;
    while (busA.SRAM0_nWE !== 1'b0 && c < 50) begin @(negedge clk); c++; end
    checks++; if (c >= 50) begin errors++; $display("FAIL rst_strobe_wait got timeout exp nWE=0"); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (busA.SRAM0_nCS !== 1'b1) begin errors++; $display("FAIL rst_mid_nCS got %b exp 1", busA.SRAM0_nCS); end
    checks++; if (busA.SRAM0_nWE !== 1'b1) begin errors++; $display("FAIL rst_mid_nWE got %b exp 1", busA.SRAM0_nWE); end
    checks++; if (busA.SRAM0_D_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_Doe got %b exp 0", busA.SRAM0_D_oe); end
    checks++; if (busA.overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b exp 0", busA.overflow); end
    qA.delete(); qB.delete();
    repeat (40) @(negedge clk);
    checks++; if (qA.size() !== 0) begin errors++; $display("FAIL rst_fifo_empty got %0d writes exp 0", qA.size()); end
    for (int i = 0; i < 5; i++) pix[i] = 3'b101;
    sendLine(6, 5);
    waitWrites(1'b0, 1, 100);
    checks++; if (qA.size() < 1 || qA[0] !== {18'd864, 16'h5B6D}) begin errors++;
      $display("FAIL rst_next_line got n=%0d a=%0d d=%h exp a=864 d=5b6d", qA.size(),
               (qA.size() > 0) ? qA[0].a : 18'd0, (qA.size() > 0) ? qA[0].d : 16'd0); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_early_de();
    qA.delete(); qB.delete();
    for (int i = 0; i < 7; i++) pix[i] = 3'(i + 1);
    sendLine(10, 7);
    waitWrites(1'b0, 2, 100);
    checks++; if (qA.size() < 2 || qA[0] !== {18'd1440, 16'h58D1}) begin errors++;
      $display("FAIL early_w0 got n=%0d a=%0d d=%h exp a=1440 d=58d1", qA.size(),
               (qA.size() > 0) ? qA[0].a : 18'd0, (qA.size() > 0) ? qA[0].d : 16'd0); end
    checks++; if (qA.size() < 2 || qA[1] !== {18'd1441, 16'h003E}) begin errors++;
      $display("FAIL early_w1 got n=%0d a=%0d d=%h exp a=1441 d=003e", qA.size(),
               (qA.size() > 1) ? qA[1].a : 18'd0, (qA.size() > 1) ? qA[1].d : 16'd0); end
    qA.delete();
    for (int i = 0; i < 5; i++) pix[i] = 3'b001;
    sendLine(11, 5);
    waitWrites(1'b0, 1, 100);
    repeat (10) @(negedge clk);
    checks++; if (qA.size() != 1 || qA[0] !== {18'd1584, 16'h1249}) begin errors++;
      $display("FAIL early_next got n=%0d a=%0d d=%h exp n=1 a=1584 d=1249", qA.size(),
               (qA.size() > 0) ? qA[0].a : 18'd0, (qA.size() > 0) ? qA[0].d : 16'd0); end
  endtask

  initial begin
    test_reset();
    test_latency_timing();
    test_full_line();
    test_width_722();
    test_hold_overflow();
    test_reset_strobe();
    test_early_de();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
